bus_master: RTL and testbench

Single-outstanding bus initiator that turns CPU-side load/store requests into STB/ACK bus cycles toward memory-mapped peripherals such as the millisecond/second pulse counter. It drives STB, WE, ADR_O and DAT_O, waits for the peripheral's ACK, captures DAT_I on reads, and returns the result with a one-cycle done pulse. It bounds every cycle with a timeout so an unresponsive peripheral cannot stall the CPU. It sits between the CPU memory stage and the peripheral address decoder.

---
 rtl/bus_master_pkg.sv | 11 +
 rtl/bus_master.sv | 106 ++++++++++
 tb/tb_bus_master.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_master_pkg.sv
// Shared constants for the single-outstanding STB/ACK bus initiator.
package bus_master_pkg;

    localparam int unsigned BUS_W = 32;

    localparam logic [BUS_W-1:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUS  = 1'b1;

endpackage

// File: rtl/bus_master.sv
// Single-outstanding STB/ACK bus initiator with per-cycle timeout.
// Latency 2+N cycles (N wait states), 1+TIMEOUT on timeout; req ignored while busy.
module bus_master
    import bus_master_pkg::*;
#(
    parameter int unsigned        TIMEOUT  = 255,
    parameter logic [BUS_W-1:0]   ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [BUS_W-1:0] addr,
    input  logic [BUS_W-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BUS_W-1:0] rdata,
    output logic             STB,
    output logic             WE,
    output logic [BUS_W-1:0] ADR_O,
    output logic [BUS_W-1:0] DAT_O,
    input  logic [BUS_W-1:0] DAT_I,
    input  logic             ACK
);

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    logic [0:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [BUS_W-1:0] adr_q, adr_d;
    logic [BUS_W-1:0] dat_q, dat_d;
    logic [BUS_W-1:0] rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_BUS;
                    we_d    = we;
                    adr_d   = addr;
                    dat_d   = wdata;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                // ACK is checked first so an ack on the last permitted cycle wins
                if (ACK) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (!we_q) rdata_d = DAT_I;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = ERR_DATA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy  = (state_q == ST_BUS);
    assign STB   = (state_q == ST_BUS);
    assign WE    = we_q;
    assign ADR_O = adr_q;
    assign DAT_O = dat_q;
    assign rdata = rdata_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: scoreboard of expected completions plus per-scenario checks.
module tb_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        STB;
    logic        WE;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        ACK;

    // slave model
    logic        ack_en;
    logic [7:0]  ack_wait;
    logic        ack_idle;
    logic [7:0]  stb_cnt;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          stb_len;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_rdata;
    int          stb_run;
    int          total;
    int          bad;

    always #5 clk = ~clk;

    bus_master #(
        .TIMEOUT (4),
        .ERR_DATA(32'hFFFF_FFFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .busy (busy),
        .done (done),
        .err  (err),
        .rdata(rdata),
        .STB  (STB),
        .WE   (WE),
        .ADR_O(ADR_O),
        .DAT_O(DAT_O),
        .DAT_I(DAT_I),
        .ACK  (ACK)
    );

    assign ACK = (STB && ack_en && (stb_cnt == ack_wait)) || ack_idle;

    always @(posedge clk) begin
        if (reset || !STB) stb_cnt <= 8'd0;
        else               stb_cnt <= stb_cnt + 8'd1;
    end

    // scoreboard monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            if (STB) begin
                stb_run++;
                if (exp_q.size() > 0) begin
                    total++;
                    if ({WE, ADR_O, DAT_O} !== {exp_q[0].we, exp_q[0].addr, exp_q[0].wdata}) begin
                        bad++;
                        $display("FAIL bus_fields: got we=%b adr=%h dat=%h want we=%b adr=%h dat=%h",
                                 WE, ADR_O, DAT_O, exp_q[0].we, exp_q[0].addr, exp_q[0].wdata);
                    end
                end
            end
            total++;
            if (err === 1'b1 && done !== 1'b1) begin
                bad++;
                $display("FAIL err_without_done: err=%b done=%b", err, done);
            end
            if (done === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_done: done=1 with nothing outstanding");
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e.rdata || err !== e.err || stb_run != e.stb_len) begin
                        bad++;
                        $display("FAIL completion: got rdata=%h err=%b stb_len=%0d want rdata=%h err=%b stb_len=%0d",
                                 rdata, err, stb_run, e.rdata, e.err, e.stb_len);
                    end
                end
                stb_run = 0;
            end
        end
    end

    // Drive one request and measure cycles from the sampling edge to done.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d, output int lat);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, err, STB, WE} !== 5'b0 || ADR_O !== 32'h0 || DAT_O !== 32'h0 || rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b err=%b STB=%b WE=%b ADR=%h DAT=%h rdata=%h want all zero",
                     busy, done, err, STB, WE, ADR_O, DAT_O, rdata);
        end
        reset = 1'b0;
        model_rdata = 32'h0;
    endtask

    task automatic test_zero_wait_read;
        int lat;
        ack_en = 1'b1; ack_wait = 8'd0; DAT_I = 32'h0000_0005;
        exp_q.push_back('{1'b0, 32'h4000_0000, 32'h0, 32'h0000_0005, 1'b0, 1});
        model_rdata = 32'h0000_0005;
        run_txn(1'b0, 32'h4000_0000, 32'h0, lat);
        total++;
        if (lat != 2) begin
            bad++;
            $display("FAIL zero_wait_latency: got %0d want 2", lat);
        end
        total++;
        if (busy !== 1'b0 || STB !== 1'b0) begin
            bad++;
            $display("FAIL zero_wait_idle: busy=%b STB=%b want 0 0", busy, STB);
        end
    endtask

    task automatic test_write_waits;
        int lat;
        ack_en = 1'b1; ack_wait = 8'd3; DAT_I = 32'hDEAD_BEEF;
        exp_q.push_back('{1'b1, 32'h4000_0010, 32'hA5A5_0001, model_rdata, 1'b0, 4});
        run_txn(1'b1, 32'h4000_0010, 32'hA5A5_0001, lat);
        total++;
        if (lat != 5) begin
            bad++;
            $display("FAIL write_wait_latency: got %0d want 5", lat);
        end
        repeat (2) @(negedge clk);
        total++;
        if (rdata !== model_rdata) begin
            bad++;
            $display("FAIL rdata_hold: got %h want %h", rdata, model_rdata);
        end
    endtask

    task automatic test_timeout_read;
        int lat;
        ack_en = 1'b0; DAT_I = 32'h1234_5678;
        exp_q.push_back('{1'b0, 32'h4000_0020, 32'h0, 32'hFFFF_FFFF, 1'b1, 4});
        model_rdata = 32'hFFFF_FFFF;
        run_txn(1'b0, 32'h4000_0020, 32'h0, lat);
        total++;
        if (lat != 5) begin
            bad++;
            $display("FAIL timeout_latency: got %0d want 5", lat);
        end
    endtask

    task automatic test_boundary_ack;
        int lat;
        ack_en = 1'b1; ack_wait = 8'd3; DAT_I = 32'h0000_0007;
        exp_q.push_back('{1'b0, 32'h4000_0030, 32'h0, 32'h0000_0007, 1'b0, 4});
        model_rdata = 32'h0000_0007;
        run_txn(1'b0, 32'h4000_0030, 32'h0, lat);
        total++;
        if (lat != 5 || err !== 1'b0) begin
            bad++;
            $display("FAIL boundary_ack: got lat=%0d err=%b want lat=5 err=0", lat, err);
        end
    endtask

    task automatic test_timeout_write;
        int lat;
        ack_en = 1'b0;
        exp_q.push_back('{1'b1, 32'h4000_0040, 32'h0BAD_0001, model_rdata, 1'b1, 4});
        run_txn(1'b1, 32'h4000_0040, 32'h0BAD_0001, lat);
        total++;
        if (lat != 5) begin
            bad++;
            $display("FAIL timeout_write_latency: got %0d want 5", lat);
        end
    endtask

    task automatic test_back_to_back;
        ack_en = 1'b1; ack_wait = 8'd0; DAT_I = 32'h0000_0011;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h4000_0A00; wdata = 32'h0;
        exp_q.push_back('{1'b0, 32'h4000_0A00, 32'h0, 32'h0000_0011, 1'b0, 1});
        model_rdata = 32'h0000_0011;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || STB !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_busy: busy=%b STB=%b want 1 1", busy, STB);
        end
        addr = 32'h4000_0C00; we = 1'b1; wdata = 32'hCCCC_CCCC;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || STB !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first_done: done=%b busy=%b STB=%b want 1 0 0", done, busy, STB);
        end
        addr = 32'h4000_0B00; we = 1'b1; wdata = 32'hB0B0_0002;
        exp_q.push_back('{1'b1, 32'h4000_0B00, 32'hB0B0_0002, model_rdata, 1'b0, 1});
        @(negedge clk);
        req = 1'b0;
        total++;
        if (STB !== 1'b1 || ADR_O !== 32'h4000_0B00) begin
            bad++;
            $display("FAIL b2b_second_start: STB=%b ADR=%h want 1 40000b00", STB, ADR_O);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_done: done=%b want 1", done);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (STB !== 1'b0) begin
                bad++;
                $display("FAIL b2b_no_queue: STB=%b at idle cycle %0d want 0", STB, i);
            end
        end
    endtask

    task automatic test_spurious_ack;
        ack_idle = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || rdata !== model_rdata) begin
                bad++;
                $display("FAIL idle_ack_ignored: busy=%b rdata=%h want 0 %h", busy, rdata, model_rdata);
            end
        end
        ack_idle = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int lat;
        ack_en = 1'b0;
        exp_q.push_back('{1'b0, 32'h4000_0D00, 32'h0, 32'h0, 1'b0, 0});
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h4000_0D00; wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (STB !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: STB=%b busy=%b done=%b err=%b want all 0", STB, busy, done, err);
        end
        reset = 1'b0;
        exp_q.delete();
        stb_run = 0;
        model_rdata = 32'h0;
        repeat (4) @(negedge clk);
        ack_en = 1'b1; ack_wait = 8'd1; DAT_I = 32'h0BAD_F00D;
        exp_q.push_back('{1'b0, 32'h4000_0E00, 32'h0, 32'h0BAD_F00D, 1'b0, 2});
        model_rdata = 32'h0BAD_F00D;
        run_txn(1'b0, 32'h4000_0E00, 32'h0, lat);
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL post_reset_latency: got %0d want 3", lat);
        end
    endtask

    initial begin
        total = 0; bad = 0; stb_run = 0; model_rdata = 32'h0;
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
        DAT_I = 32'h0; ack_en = 1'b0; ack_wait = 8'd0; ack_idle = 1'b0;
        test_reset();
        test_zero_wait_read();
        test_write_waits();
        test_timeout_read();
        test_boundary_ack();
        test_timeout_write();
        test_back_to_back();
        test_spurious_ack();
        test_reset_abort();
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_done: %0d completions outstanding want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
